// File: rtl/emergency_arbiter.sv
// emergency_arbiter: synchronises and debounces N_CH emergency requests, grants
// one approach direction at a time (lowest index wins), keeps the grant for at
// least MIN_HOLD cycles and then drives an all-red clearance of CLEAR_CYCLES
// cycles before arbitrating again. All outputs are registered.
// Optional build macro EMERG_PREEMPT_EN: a debounced request on a lower index
// than the current grant cuts the grant short and forces clearance.
module emergency_arbiter #(
  parameter int N_CH           = 4,
  parameter int DEBOUNCE_LIMIT = 5,
  parameter int MIN_HOLD       = 16,
  parameter int CLEAR_CYCLES   = 8,
  localparam int IDX_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  btn_emerg_raw,
  output logic [N_CH-1:0]  req_deb,
  output logic             emerg_active,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             clearance
);

  localparam int DB_W   = (DEBOUNCE_LIMIT > 0) ? $clog2(DEBOUNCE_LIMIT + 1) : 1;
  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam int CLR_W  = $clog2(CLEAR_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_LIMIT);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
  localparam logic [CLR_W-1:0]  CLR_MAX  = CLR_W'(CLEAR_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_CLEAR} state_t;

  logic [N_CH-1:0]   r_sync1;
  logic [N_CH-1:0]   r_sync2;
  logic [N_CH-1:0]   w_deb;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [CLR_W-1:0]  r_clr_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [CLR_W-1:0]  w_clr_nxt;
  logic [IDX_W-1:0]  w_sel;
  logic              w_any;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [N_CH-1:0]   w_grant_nxt;
  logic              w_clear_nxt;
  logic              w_active_nxt;
  logic              w_hold_done;
  logic              w_grant_exit;

  // two-flop synchroniser for the asynchronous raw requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_emerg_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_deb
    logic [DB_W-1:0] r_cnt;
    logic            r_deb;
    // per-channel debounce: adopt the synchronised level after DEBOUNCE_LIMIT+1 mismatching cycles
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
        r_deb <= 1'b0;
      end else if (r_sync2[g] != r_deb) begin
        if (r_cnt == DB_MAX) begin
          r_deb <= r_sync2[g];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + DB_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
    assign w_deb[g] = r_deb;
  end

  assign req_deb = w_deb;

  // fixed-priority pick of the lowest set debounced request
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_deb[i] && !w_any) begin
        w_sel = IDX_W'(i);
        w_any = 1'b1;
      end
    end
  end

  assign w_hold_done = (r_hold_cnt == HOLD_MAX) && !w_deb[grant_idx];

`ifdef EMERG_PREEMPT_EN
  logic w_preempt;
  // any debounced request of higher priority than the current grant
  always_comb begin
    w_preempt = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_deb[i] && (IDX_W'(i) < grant_idx)) w_preempt = 1'b1;
    end
  end
  assign w_grant_exit = w_hold_done || w_preempt;
`else
  assign w_grant_exit = w_hold_done;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_GRANT;
      S_GRANT: if (w_grant_exit) w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_clr_cnt == CLR_MAX) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // next values of the registered outputs and counters, keyed on the transition
  always_comb begin
    w_idx_nxt  = grant_idx;
    w_hold_nxt = '0;
    w_clr_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_idx_nxt  = w_sel;
          w_hold_nxt = HOLD_W'(1);
        end
      end
      S_GRANT: begin
        if (w_grant_exit)                w_clr_nxt  = CLR_W'(1);
        else if (r_hold_cnt == HOLD_MAX) w_hold_nxt = r_hold_cnt;
        else                             w_hold_nxt = r_hold_cnt + HOLD_W'(1);
      end
      S_CLEAR: begin
        if (r_clr_cnt != CLR_MAX) w_clr_nxt = r_clr_cnt + CLR_W'(1);
      end
      default: ;
    endcase
    w_grant_nxt  = (w_state_nxt == S_GRANT) ? (N_CH'(1) << w_idx_nxt) : '0;
    w_clear_nxt  = (w_state_nxt == S_CLEAR);
    w_active_nxt = (w_state_nxt != S_IDLE);
  end

  // output and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant        <= '0;
      grant_idx    <= '0;
      clearance    <= 1'b0;
      emerg_active <= 1'b0;
      r_hold_cnt   <= '0;
      r_clr_cnt    <= '0;
    end else begin
      grant        <= w_grant_nxt;
      grant_idx    <= w_idx_nxt;
      clearance    <= w_clear_nxt;
      emerg_active <= w_active_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_clr_cnt    <= w_clr_nxt;
    end
  end

endmodule

// File: doc/emergency_arbiter.md
Name: emergency_arbiter

Overview:
Multi-channel successor to the single-button emergency override. It synchronises and debounces N_CH emergency request inputs, one per approach direction. A priority FSM grants exactly one direction at a time, holds that grant for a minimum time, then enforces an all-red clearance interval before returning control. It sits between the raw emergency inputs and the traffic-light sequencer, which obeys emerg_active, grant and clearance.

Parameters:
N_CH, 4, number of emergency request channels (>=1)
DEBOUNCE_LIMIT, 5, debounce length; a stable mismatch for DEBOUNCE_LIMIT+1 cycles changes the debounced state (>=0)
MIN_HOLD, 16, minimum number of cycles a grant stays asserted (>=1)
CLEAR_CYCLES, 8, all-red clearance length in cycles (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
btn_emerg_raw  input  N_CH  raw asynchronous requests, bit i = channel i
req_deb  output  N_CH  debounced request state per channel
emerg_active  output  1  high while the FSM is in GRANT or CLEAR
grant  output  N_CH  one-hot granted channel, all zero outside GRANT
grant_idx  output  max(1,$clog2(N_CH))  index of the granted or last-granted channel
clearance  output  1  high only in CLEAR

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. Reset clears every flop immediately, including mid-grant and mid-clear.
- Reset values: req_deb=0, emerg_active=0, grant=0, grant_idx=0, clearance=0, FSM=IDLE, all counters 0.
- Synchroniser: two flops per channel, reset to 0.
- Debounce, per channel, with counter width $clog2(DEBOUNCE_LIMIT+1) (minimum 1):
  - sync!=req_deb and cnt<DEBOUNCE_LIMIT -> cnt+1.
  - sync!=req_deb and cnt==DEBOUNCE_LIMIT -> req_deb<=sync, cnt<=0.
  - sync==req_deb -> cnt<=0.
  - Latency from a raw edge to a req_deb edge is DEBOUNCE_LIMIT+3 clocks. Glitches shorter than DEBOUNCE_LIMIT+1 synchronised cycles are rejected.
- All outputs are registered.
- FSM state IDLE:
  - If any req_deb bit is set, select the lowest set index (fixed priority, channel 0 highest).
  - On that edge: enter GRANT, grant<=onehot(sel), grant_idx<=sel, hold_cnt<=1.
  - Grant therefore asserts 1 cycle after req_deb rises.
- FSM state GRANT:
  - hold_cnt increments, saturating at MIN_HOLD.
  - Exit to CLEAR when hold_cnt==MIN_HOLD and req_deb[grant_idx]==0. On that edge grant<=0, clearance<=1, clr_cnt<=1.
  - If the request is already released, grant is high for exactly MIN_HOLD cycles. If still held, grant stays high until it is released.
  - Other requests arriving during GRANT are ignored; no preemption by default.
- FSM state CLEAR:
  - Lasts exactly CLEAR_CYCLES cycles. When clr_cnt==CLEAR_CYCLES, go to IDLE and clearance<=0.
  - Requests are not sampled in CLEAR.
- IDLE always lasts at least 1 cycle before a new grant.
- emerg_active = GRANT or CLEAR; it is a registered copy that changes on the same edges as grant and clearance.
- grant_idx holds its value in CLEAR and IDLE.
- Simultaneous requests resolve to the lowest index. Higher indices are served in later rounds if still asserted.

Optional Feature:
Macro EMERG_PREEMPT_EN.
- Defined: in GRANT, a debounced request on any index lower than grant_idx forces GRANT->CLEAR on the next edge, ignoring MIN_HOLD. After CLEAR, IDLE re-arbitrates and normally grants the preempting channel.
- Undefined: no preemption logic is compiled; GRANT exits only by the MIN_HOLD/release rule.

Test Plan:
- Reset, then a 3-cycle pulse on ch1 (DEBOUNCE_LIMIT=5) -> req_deb stays 0 and emerg_active stays 0.
- Hold ch2 high 10 cycles, then release -> req_deb[2] rises 8 clocks after the raw edge. grant=4'b0100 and grant_idx=2 for exactly 16 cycles, then clearance=1 for 8 cycles, then all outputs 0.
- Hold ch0 for 40 cycles -> grant stays 4'b0001 until req_deb[0] falls, then 8 cycles of clearance.
- ch1 and ch3 rise in the same cycle and stay high -> ch1 is granted first; after its clear, ch3 is granted (after ch1 is released).
- ch3 granted, ch0 requested at hold_cnt=4 -> without the macro, ch3 keeps its grant for all 16 cycles. With EMERG_PREEMPT_EN, clearance starts on the next edge and ch0 is granted after 8 clearance cycles plus 1 idle cycle.
- Assert rst during CLEAR and again during GRANT -> all outputs 0 immediately (asynchronously). The FSM restarts in IDLE and a held request re-debounces from scratch.
